// File: rtl/easyaxi_slv.sv
// ---------------------------------------------------------------------------
// easyaxi_slv
//
// Far-end responder for an EASYAXI_MST-style AR channel. Accepted AR requests
// are queued in a small in-order FIFO. A response engine pops one entry at a
// time, waits RSP_DLY cycles and then presents a single-beat R response. The
// read data is derived from the request (araddr + arid), so every beat is
// predictable.
//
// Parameters:
//   DATA_WIDTH  R-channel data width (>= AXI_ADDR_WIDTH)
//   FIFO_DEPTH  outstanding AR entries (power of two, >= 2)
//   RSP_DLY     wait cycles between pop and rvalid (0..255)
//   ADDR_MAX    highest decodable address (decode-error build only)
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   axi_slv_arvalid/arready         AR handshake
//   axi_slv_arid, axi_slv_araddr    AR payload
//   axi_slv_rvalid/rready           R handshake
//   axi_slv_rid, rdata, rresp, rlast  R payload (single beat, rlast always 1)
//
// Build option:
//   EASYAXI_SLV_DECERR_EN  when defined, araddr > ADDR_MAX answers DECERR
//                          (rresp=2'b11, rdata=0). Default build: always OKAY.
//
// ID/address widths come from AXI_ID_WIDTH / AXI_ADDR_WIDTH; defaults are
// supplied here when no project-wide definition is present.
// ---------------------------------------------------------------------------
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 16
`endif

module easyaxi_slv #(
    parameter int                         DATA_WIDTH = 32,
    parameter int                         FIFO_DEPTH = 4,
    parameter int                         RSP_DLY    = 2,
    parameter logic [`AXI_ADDR_WIDTH-1:0] ADDR_MAX   = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       axi_slv_arvalid,
    output logic                       axi_slv_arready,
    input  logic [`AXI_ID_WIDTH-1:0]   axi_slv_arid,
    input  logic [`AXI_ADDR_WIDTH-1:0] axi_slv_araddr,
    output logic                       axi_slv_rvalid,
    input  logic                       axi_slv_rready,
    output logic [`AXI_ID_WIDTH-1:0]   axi_slv_rid,
    output logic [DATA_WIDTH-1:0]      axi_slv_rdata,
    output logic [1:0]                 axi_slv_rresp,
    output logic                       axi_slv_rlast
);

    localparam int ID_W   = `AXI_ID_WIDTH;
    localparam int ADDR_W = `AXI_ADDR_WIDTH;
    localparam int ENT_W  = ID_W + ADDR_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [7:0]     DLY_LOAD = 8'(RSP_DLY);

`ifdef EASYAXI_SLV_DECERR_EN
    localparam bit DECERR_EN = 1'b1;
`else
    localparam bit DECERR_EN = 1'b0;
`endif

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // -----------------------------------------------------------------------
    // AR FIFO
    // -----------------------------------------------------------------------
    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              push;
    logic              pop;
    logic [ID_W-1:0]   head_id;
    logic [ADDR_W-1:0] head_addr;

    state_t            state;
    logic [7:0]        dly_cnt;

    // Ready depends only on registered occupancy, never on arvalid.
    assign axi_slv_arready = (count != FULL_CNT);
    assign push            = axi_slv_arvalid & axi_slv_arready;
    // The pop is the engine's IDLE->WAIT transition.
    assign pop             = (state == ST_IDLE) && (count != '0);

    assign {head_id, head_addr} = fifo_mem[rd_ptr];

    // NOTE: the storage array carries no reset; validity is tracked by count
    // and the pointers, so resetting the entries would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {axi_slv_arid, axi_slv_araddr};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are log2(depth) bits wide, so they wrap naturally.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Response payload for the FIFO head
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [1:0]            rsp_resp;

    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rsp_resp = RESP_OKAY;
        rsp_data = DATA_WIDTH'(head_addr) + DATA_WIDTH'(head_id);
        // Constant-folds away in the default build.
        if (DECERR_EN && (head_addr > ADDR_MAX)) begin
            rsp_resp = RESP_DECERR;
            rsp_data = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Response engine: IDLE -> WAIT (RSP_DLY cycles) -> RESP
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            dly_cnt        <= '0;
            axi_slv_rvalid <= 1'b0;
            axi_slv_rlast  <= 1'b0;
            axi_slv_rid    <= '0;
            axi_slv_rdata  <= '0;
            axi_slv_rresp  <= RESP_OKAY;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        // Payload is latched here and stays put through RESP.
                        axi_slv_rid   <= head_id;
                        axi_slv_rdata <= rsp_data;
                        axi_slv_rresp <= rsp_resp;
                        dly_cnt       <= DLY_LOAD;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dly_cnt == '0) begin
                        axi_slv_rvalid <= 1'b1;
                        axi_slv_rlast  <= 1'b1;
                        state          <= ST_RESP;
                    end else begin
                        dly_cnt <= dly_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (axi_slv_rready) begin
                        axi_slv_rvalid <= 1'b0;
                        axi_slv_rlast  <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: begin
                    axi_slv_rvalid <= 1'b0;
                    axi_slv_rlast  <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_easyaxi_slv.sv
// ---------------------------------------------------------------------------
// tb_easyaxi_slv
//
// Directed bench for easyaxi_slv (default parameters: 32-bit data, depth 4,
// RSP_DLY 2, ADDR_MAX 0). Inputs change 1 time unit after the rising edge;
// outputs are sampled at that same point, away from the edge.
// ---------------------------------------------------------------------------
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 16
`endif

module tb_easyaxi_slv;

    localparam int ID_W   = `AXI_ID_WIDTH;
    localparam int ADDR_W = `AXI_ADDR_WIDTH;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '0;
    localparam int N_SW = 18;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [ID_W-1:0]   arid = '0;
    logic [ADDR_W-1:0] araddr = '0;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    int n_vec = 0;
    int n_err = 0;

    logic [ID_W-1:0]   sw_id   [N_SW];
    logic [ADDR_W-1:0] sw_addr [N_SW];

    easyaxi_slv #(
        .DATA_WIDTH (DATA_W),
        .FIFO_DEPTH (4),
        .RSP_DLY    (2),
        .ADDR_MAX   (ADDR_MAX)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .axi_slv_arvalid (arvalid),
        .axi_slv_arready (arready),
        .axi_slv_arid    (arid),
        .axi_slv_araddr  (araddr),
        .axi_slv_rvalid  (rvalid),
        .axi_slv_rready  (rready),
        .axi_slv_rid     (rid),
        .axi_slv_rdata   (rdata),
        .axi_slv_rresp   (rresp),
        .axi_slv_rlast   (rlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_data(input logic [ID_W-1:0] id,
                                                   input logic [ADDR_W-1:0] addr);
`ifdef EASYAXI_SLV_DECERR_EN
        if (addr > ADDR_MAX) return '0;
`endif
        return DATA_W'(addr) + DATA_W'(id);
    endfunction

    function automatic logic [1:0] exp_resp(input logic [ADDR_W-1:0] addr);
`ifdef EASYAXI_SLV_DECERR_EN
        if (addr > ADDR_MAX) return 2'b11;
`endif
        return 2'b00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold one AR until it is accepted (bounded).
    task automatic send_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr);
        bit done = 1'b0;
        arvalid = 1'b1;
        arid    = id;
        araddr  = addr;
        for (int k = 0; k < 200 && !done; k++) begin
            done = arready;
            tick();
        end
        if (!done) check("ar_timeout", arready, 1);
        arvalid = 1'b0;
    endtask

    // Accept one R beat (bounded wait) and compare its payload.
    task automatic recv_beat(input string tag, input logic [ID_W-1:0] id,
                             input logic [DATA_W-1:0] data, input logic [1:0] resp);
        int k = 0;
        rready = 1'b1;
        while (!rvalid && k < 200) begin
            tick();
            k++;
        end
        check({tag, "_rvalid"}, rvalid, 1);
        if (rvalid) begin
            check({tag, "_rid"},   rid,   id);
            check({tag, "_rdata"}, rdata, data);
            check({tag, "_rresp"}, rresp, resp);
            check({tag, "_rlast"}, rlast, 1);
            tick();
        end
        rready = 1'b0;
    endtask

    task automatic wait_rvalid(input string tag);
        int k = 0;
        while (!rvalid && k < 200) begin
            tick();
            k++;
        end
        check({tag, "_rvalid"}, rvalid, 1);
    endtask

    initial begin
        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("rst_arready", arready, 1);
        check("rst_rvalid",  rvalid,  0);
        check("rst_rlast",   rlast,   0);
        check("rst_rid",     rid,     0);
        check("rst_rdata",   rdata,   0);
        check("rst_rresp",   rresp,   0);

        // ---------------- single request, latency T+5 ----------------
        rready  = 1'b1;
        arvalid = 1'b1;
        arid    = '0;
        araddr  = '0;
        check("one_arready_T", arready, 1);
        tick();                              // handshake at cycle T
        arvalid = 1'b0;
        for (int k = 1; k <= 5; k++) begin   // now at cycle T+k
            check("one_lat_rvalid", rvalid, (k == 5));
            check("one_arready", arready, 1);
            if (k < 5) tick();
        end
        check("one_rid",   rid,   0);
        check("one_rdata", rdata, 0);
        check("one_rresp", rresp, 0);
        check("one_rlast", rlast, 1);
        tick();
        check("one_rvalid_drop", rvalid, 0);
        rready = 1'b0;

        // ---------------- ID/address sweep ----------------
        for (int i = 0; i < 16; i++) begin
            sw_id[i]   = ID_W'(i);
            sw_addr[i] = (i < 8) ? ADDR_W'(0) : ADDR_W'(1);
        end
        sw_id[16] = 4'd15; sw_addr[16] = 16'hFFFF;   // 0x0001_000E
        sw_id[17] = 4'd9;  sw_addr[17] = 16'hABCD;   // 0x0000_ABD6
        fork
            begin
                for (int i = 0; i < N_SW; i++) send_ar(sw_id[i], sw_addr[i]);
            end
            begin
                for (int i = 0; i < N_SW; i++)
                    recv_beat("sweep", sw_id[i], exp_data(sw_id[i], sw_addr[i]),
                              exp_resp(sw_addr[i]));
            end
        join
        repeat (2) tick();

        // ---------------- fill and stall ----------------
        rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            arvalid = 1'b1;
            arid    = ID_W'(i + 1);
            araddr  = ADDR_W'((i + 1) * 256);
            check("fill_arready", arready, 1);
            tick();
        end
        arvalid = 1'b1;                      // 6th request, cycle T+5
        arid    = 4'd6;
        araddr  = 16'h0600;
        check("full_arready", arready, 0);
        check("fill_lat_rvalid", rvalid, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_arready", arready, 0);
            check("stall_rvalid",  rvalid,  1);
            check("stall_rid",     rid,     1);
            check("stall_rdata",   rdata,   32'h0000_0101);
        end
        rready = 1'b1;                       // handshake cycle C
        tick();                              // C+1: engine IDLE
        rready = 1'b0;
        check("rel_arready_c1", arready, 0);
        check("rel_rvalid_c1",  rvalid,  0);
        tick();                              // C+2: slot freed
        check("rel_arready_c2", arready, 1);
        tick();                              // 6th request accepted
        arvalid = 1'b0;
        for (int i = 2; i <= 6; i++)
            recv_beat("fill", ID_W'(i), exp_data(ID_W'(i), ADDR_W'(i * 256)),
                      exp_resp(ADDR_W'(i * 256)));
        repeat (2) tick();

        // ---------------- push and pop together at count 3 ----------------
        rready = 1'b0;
        send_ar(4'd2, 16'h0020);             // A, popped immediately
        send_ar(4'd3, 16'h0030);             // B
        send_ar(4'd4, 16'h0040);             // C
        send_ar(4'd5, 16'h0050);             // D -> count 3
        wait_rvalid("sim_a");
        check("sim_cnt3_arready", arready, 1);
        check("sim_a_rdata", rdata, exp_data(4'd2, 16'h0020));
        rready = 1'b1;                       // A handshake
        tick();
        rready  = 1'b0;
        arvalid = 1'b1;                      // E pushed on the B pop edge
        arid    = 4'd6;
        araddr  = 16'h0060;
        check("sim_pre_arready", arready, 1);
        tick();
        check("sim_same_edge_arready", arready, 1);
        arid   = 4'd7;                       // F fills the FIFO
        araddr = 16'h0070;
        tick();
        arvalid = 1'b0;
        check("sim_full_arready", arready, 0);
        for (int i = 3; i <= 7; i++)
            recv_beat("sim", ID_W'(i), exp_data(ID_W'(i), ADDR_W'(i * 16)),
                      exp_resp(ADDR_W'(i * 16)));
        repeat (2) tick();

        // ---------------- reset during RESP ----------------
        rready = 1'b0;
        send_ar(4'd7, 16'h7000);
        send_ar(4'd8, 16'h8000);
        send_ar(4'd9, 16'h9000);
        wait_rvalid("rstm");
        #1 rst_n = 1'b0;                     // mid-cycle, no clock edge
        #1;
        check("rstm_rvalid_async", rvalid,  0);
        check("rstm_rlast_async",  rlast,   0);
        check("rstm_arready",      arready, 1);
        check("rstm_rid",          rid,     0);
        check("rstm_rdata",        rdata,   0);
        #2 rst_n = 1'b1;
        rready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("rstm_no_stale", rvalid, 0);
        end
        rready = 1'b0;

        // ---------------- decode check: id 3, addr 1 ----------------
        send_ar(4'd3, 16'h0001);
`ifdef EASYAXI_SLV_DECERR_EN
        recv_beat("decode", 4'd3, 32'h0000_0000, 2'b11);
`else
        recv_beat("decode", 4'd3, 32'h0000_0004, 2'b00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
